axon_spike_scheduler: RTL and testbench

// - Responder side of the core's scheduler interface: buffers incoming routed spikes by delivery tick and serves one 256-bit axon-activity vector per tick.
// - Sits between the router (spike input) and the token controller (read/clear requester).
// - Holds a 16-slot ring of axon vectors; the slot pointer advances on each 1 kHz tick.

---
 rtl/truenorth_pkg.sv | 28 ++
 rtl/axon_slot_ram.sv | 39 +++
 rtl/axon_spike_scheduler.sv | 91 +++++++++
 tb/tb_axon_spike_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/truenorth_pkg.sv
// Shared core constants and spike packet layout used by router, scheduler and token controller.
package truenorth_pkg;

  localparam int unsigned NUM_AXONS = 256;
  localparam int unsigned NUM_SLOTS = 16;
  localparam int unsigned AXON_W    = 8;
  localparam int unsigned SLOT_W    = 4;
  localparam int unsigned CNT_W     = 8;

  // Spike packet field offsets: {delivery_tick, axon}
  localparam int unsigned PKT_AXON_LSB  = 0;
  localparam int unsigned PKT_DELIV_LSB = AXON_W;
  localparam int unsigned PKT_W         = AXON_W + SLOT_W;

  typedef logic [AXON_W-1:0] axon_idx_t;
  typedef logic [SLOT_W-1:0] slot_idx_t;

  typedef struct packed {
    slot_idx_t delivery;
    axon_idx_t axon;
  } spike_pkt_t;

  // Ring slot for a spike; wraps naturally because NUM_SLOTS is a power of 2.
  function automatic slot_idx_t target_slot(slot_idx_t cur, slot_idx_t offset);
    return cur + offset;
  endfunction

endpackage

// File: rtl/axon_slot_ram.sv
// NUM_SLOTS x NUM_AXONS flop array: bit-set write, whole-row clear, registered row read.
module axon_slot_ram import truenorth_pkg::*; (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en_i,
  input  slot_idx_t            wr_slot_i,
  input  axon_idx_t            wr_axon_i,
  input  logic                 clr_en_i,
  input  slot_idx_t            clr_slot_i,
  input  logic                 rd_en_i,
  input  slot_idx_t            rd_slot_i,
  output logic [NUM_AXONS-1:0] rd_data_o
);

  logic [NUM_AXONS-1:0] slot_q [NUM_SLOTS];
  logic [NUM_AXONS-1:0] rd_data_q;

  // Row storage; a write and a clear never target the same row in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '{default: '0};
    end else begin
      if (clr_en_i) slot_q[clr_slot_i] <= '0;
      if (wr_en_i)  slot_q[wr_slot_i][wr_axon_i] <= 1'b1;
    end
  end

  // Registered read returns the row as it was before this edge's write/clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= slot_q[rd_slot_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axon_spike_scheduler.sv
// Buffers routed spikes by delivery tick and serves one axon-activity vector per tick.
module axon_spike_scheduler import truenorth_pkg::*; (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 spike_valid,
  output logic                 spike_ready,
  input  logic [AXON_W-1:0]    spike_axon,
  input  logic [SLOT_W-1:0]    spike_delivery_tick,
  input  logic                 scheduler_read_request,
  output logic [NUM_AXONS-1:0] axon_activity,
  output logic                 activity_valid,
  input  logic                 scheduler_clear_request,
  output logic [SLOT_W-1:0]    current_slot,
  output logic [CNT_W-1:0]     dropped_count,
  output logic                 late_error
);

  logic              ready_q;
  logic              valid_q;
  logic              late_q,  late_d;
  logic              clr_q;
  slot_idx_t         slot_q,  slot_d;
  logic [CNT_W-1:0]  drop_q,  drop_d;

  logic              accept;
  logic              late_spike;
  logic              wr_en;
  logic              clr_pulse;
  slot_idx_t         wr_slot;

  // Handshake, offset arithmetic and clear-edge detect, all against the pre-tick pointer.
  always_comb begin
    accept     = spike_valid & ready_q;
    late_spike = accept && (spike_delivery_tick == '0);
    wr_en      = accept && !late_spike;
    wr_slot    = target_slot(slot_q, spike_delivery_tick);
    clr_pulse  = scheduler_clear_request & ~clr_q;
  end

  // Next-state for pointer, saturating drop counter and sticky late flag.
  always_comb begin
    slot_d = slot_q;
    drop_d = drop_q;
    late_d = late_q;
    if (tick) slot_d = slot_q + SLOT_W'(1);
    if (late_spike) begin
      late_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      late_q  <= 1'b0;
      clr_q   <= 1'b0;
      slot_q  <= '0;
      drop_q  <= '0;
    end else begin
      ready_q <= 1'b1;
      valid_q <= scheduler_read_request;
      late_q  <= late_d;
      clr_q   <= scheduler_clear_request;
      slot_q  <= slot_d;
      drop_q  <= drop_d;
    end
  end

  axon_slot_ram u_ram (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en),
    .wr_slot_i  (wr_slot),
    .wr_axon_i  (spike_axon),
    .clr_en_i   (clr_pulse),
    .clr_slot_i (slot_q),
    .rd_en_i    (scheduler_read_request),
    .rd_slot_i  (slot_q),
    .rd_data_o  (axon_activity)
  );

  assign spike_ready    = ready_q;
  assign activity_valid = valid_q;
  assign current_slot   = slot_q;
  assign dropped_count  = drop_q;
  assign late_error     = late_q;

endmodule

// File: tb/tb_axon_spike_scheduler.sv
// Directed bench for axon_spike_scheduler: vector table plus hand-written corner sequences.
module tb_axon_spike_scheduler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tick = 1'b0;
  logic         spike_valid = 1'b0;
  logic         spike_ready;
  logic [7:0]   spike_axon = '0;
  logic [3:0]   spike_delivery_tick = '0;
  logic         scheduler_read_request = 1'b0;
  logic [255:0] axon_activity;
  logic         activity_valid;
  logic         scheduler_clear_request = 1'b0;
  logic [3:0]   current_slot;
  logic [7:0]   dropped_count;
  logic         late_error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axon_spike_scheduler dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .tick                    (tick),
    .spike_valid             (spike_valid),
    .spike_ready             (spike_ready),
    .spike_axon              (spike_axon),
    .spike_delivery_tick     (spike_delivery_tick),
    .scheduler_read_request  (scheduler_read_request),
    .axon_activity           (axon_activity),
    .activity_valid          (activity_valid),
    .scheduler_clear_request (scheduler_clear_request),
    .current_slot            (current_slot),
    .dropped_count           (dropped_count),
    .late_error              (late_error)
  );

  typedef struct {
    logic         tck;
    logic         vld;
    logic [7:0]   ax;
    logic [3:0]   off;
    logic         rd;
    logic         clr;
    logic [255:0] exp_act;
    logic         exp_av;
    logic [3:0]   exp_slot;
    logic [7:0]   exp_drop;
    logic         exp_late;
  } vec_t;

  vec_t tbl [13];

  function automatic logic [255:0] bit_at(int i);
    logic [255:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic vec_t mk(logic tck, logic vld, logic [7:0] ax, logic [3:0] off, logic rd,
                              logic clr, logic [255:0] act, logic av, logic [3:0] slot,
                              logic [7:0] drop, logic late);
    vec_t v;
    v.tck = tck; v.vld = vld; v.ax = ax; v.off = off; v.rd = rd; v.clr = clr;
    v.exp_act = act; v.exp_av = av; v.exp_slot = slot; v.exp_drop = drop; v.exp_late = late;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 ns after the active edge.
  task automatic drive(input logic tck, input logic vld, input logic [7:0] ax,
                       input logic [3:0] off, input logic rd, input logic clr);
    tick = tck;
    spike_valid = vld;
    spike_axon = ax;
    spike_delivery_tick = off;
    scheduler_read_request = rd;
    scheduler_clear_request = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0);
  endtask

  logic [255:0] slot4_exp;

  initial begin
    tbl[0]  = mk(0, 1,  5, 2, 0, 0, '0,         0, 0, 0, 0); // write slot 2
    tbl[1]  = mk(1, 0,  0, 0, 0, 0, '0,         0, 1, 0, 0);
    tbl[2]  = mk(1, 0,  0, 0, 0, 0, '0,         0, 2, 0, 0);
    tbl[3]  = mk(0, 0,  0, 0, 1, 0, bit_at(5),  1, 2, 0, 0); // read slot 2
    tbl[4]  = mk(0, 0,  0, 0, 0, 0, bit_at(5),  0, 2, 0, 0); // data holds
    tbl[5]  = mk(0, 1,  9, 0, 0, 0, bit_at(5),  0, 2, 1, 1); // late spike dropped
    tbl[6]  = mk(0, 0,  0, 0, 1, 0, bit_at(5),  1, 2, 1, 1); // axon 9 absent
    tbl[7]  = mk(0, 1,  7, 1, 0, 0, bit_at(5),  0, 2, 1, 1); // write slot 3
    tbl[8]  = mk(0, 1,  7, 1, 0, 0, bit_at(5),  0, 2, 1, 1); // duplicate, not counted
    tbl[9]  = mk(1, 0,  0, 0, 1, 0, bit_at(5),  1, 3, 1, 1); // read uses pre-tick slot
    tbl[10] = mk(0, 0,  0, 0, 1, 0, bit_at(7),  1, 3, 1, 1);
    tbl[11] = mk(1, 1, 33, 1, 1, 0, bit_at(7),  1, 4, 1, 1); // spike+read+tick together
    tbl[12] = mk(0, 0,  0, 0, 1, 0, bit_at(33), 1, 4, 1, 1);

    // Reset state, asynchronous.
    #3;
    chk("rst_ready", 256'(spike_ready), '0);
    chk("rst_act", axon_activity, '0);
    chk("rst_av", 256'(activity_valid), '0);
    chk("rst_slot", 256'(current_slot), '0);
    chk("rst_drop", 256'(dropped_count), '0);
    chk("rst_late", 256'(late_error), '0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("ready_after_rst", 256'(spike_ready), 256'(1));

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].tck, tbl[i].vld, tbl[i].ax, tbl[i].off, tbl[i].rd, tbl[i].clr);
      chk($sformatf("v%0d_act", i), axon_activity, tbl[i].exp_act);
      chk($sformatf("v%0d_av", i), 256'(activity_valid), 256'(tbl[i].exp_av));
      chk($sformatf("v%0d_slot", i), 256'(current_slot), 256'(tbl[i].exp_slot));
      chk($sformatf("v%0d_drop", i), 256'(dropped_count), 256'(tbl[i].exp_drop));
      chk($sformatf("v%0d_late", i), 256'(late_error), 256'(tbl[i].exp_late));
      chk($sformatf("v%0d_ready", i), 256'(spike_ready), 256'(1));
    end

    // Ring wrap: from slot 14, offset 3 lands in slot 1.
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0);
    chk("wrap_slot14", 256'(current_slot), 256'(14));
    drive(1'b0, 1'b1, 8'd200, 4'd3, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0);
    chk("wrap_slot15", 256'(current_slot), 256'(15));
    drive(1'b1, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0);
    chk("wrap_slot0", 256'(current_slot), 256'(0));
    drive(1'b1, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0);
    chk("wrap_slot1", 256'(current_slot), 256'(1));
    drive(1'b0, 1'b0, 8'd0, 4'd0, 1'b1, 1'b0);
    chk("wrap_act", axon_activity, bit_at(200));
    chk("wrap_av", 256'(activity_valid), 256'(1));

    // Clear held on slot 3 (holds axon 7) while offset-1 spikes fill slot 4.
    drive(1'b1, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0);
    chk("clr_slot3", 256'(current_slot), 256'(3));
    slot4_exp = bit_at(33);
    for (int k = 0; k < 11; k++) begin
      drive(k == 10, 1'b1, 8'(10 + k), 4'd1, k < 2, 1'b1);
      slot4_exp = slot4_exp | bit_at(10 + k);
      if (k == 0) chk("clr_read_preclear", axon_activity, bit_at(7));
      if (k == 1) chk("clr_read_cleared", axon_activity, '0);
    end
    chk("clr_slot4", 256'(current_slot), 256'(4));
    drive(1'b0, 1'b0, 8'd0, 4'd0, 1'b1, 1'b1);
    chk("clr_slot4_held", axon_activity, slot4_exp);
    drive(1'b0, 1'b0, 8'd0, 4'd0, 1'b1, 1'b0);
    chk("clr_slot4_once", axon_activity, slot4_exp);
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0);
    chk("clr_back_slot3", 256'(current_slot), 256'(3));
    drive(1'b0, 1'b0, 8'd0, 4'd0, 1'b1, 1'b0);
    chk("clr_slot3_zero", axon_activity, '0);

    // Drop counter saturation (count is 1 going in).
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'b1, 8'(i), 4'd0, 1'b0, 1'b0);
      if (i == 252) chk("drop_254", 256'(dropped_count), 256'(254));
    end
    chk("drop_sat", 256'(dropped_count), 256'(255));
    chk("drop_late", 256'(late_error), 256'(1));

    // Mid-stream reset with buffered spikes.
    drive(1'b1, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'd0, 4'd0, 1'b1, 1'b0);
    chk("pre_rst_act", axon_activity, slot4_exp);
    spike_valid = 1'b1;
    spike_axon = 8'd3;
    spike_delivery_tick = 4'd2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 256'(spike_ready), '0);
    chk("mid_rst_act", axon_activity, '0);
    chk("mid_rst_av", 256'(activity_valid), '0);
    chk("mid_rst_slot", 256'(current_slot), '0);
    chk("mid_rst_drop", 256'(dropped_count), '0);
    chk("mid_rst_late", 256'(late_error), '0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("post_rst_ready", 256'(spike_ready), 256'(1));
    for (int s = 0; s < 16; s++) begin
      drive(1'b1, 1'b0, 8'd0, 4'd0, 1'b1, 1'b0);
      chk($sformatf("post_rst_slot%0d", s), axon_activity, '0);
      chk($sformatf("post_rst_av%0d", s), 256'(activity_valid), 256'(1));
    end
    chk("post_rst_ptr", 256'(current_slot), '0);
    chk("post_rst_drop", 256'(dropped_count), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
